// File: rtl/tamagotchi_btn_cond.sv
// Button front end for tamagotchi_fsm: sync, debounce, press pulses and long-press timing.
// Optional care-button auto-repeat is compiled in with `define BTN_AUTOREPEAT_EN.
module tamagotchi_btn_cond #(
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SEC_CYCLES      = 50_000_000,
    parameter int HOLD_SECS       = 5,
    parameter int REPEAT_CYCLES   = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_salud,
    input  logic       raw_energia,
    input  logic       raw_hambre,
    input  logic       raw_diversion,
    input  logic       raw_reset,
    input  logic       raw_test,
    output logic       btn_salud,
    output logic       btn_energia,
    output logic       btn_hambre,
    output logic       btn_diversion,
    output logic       btn_reset,
    output logic       btn_test,
    output logic [2:0] count_reset,
    output logic [2:0] count_test
);

    localparam int NBTN    = 6;
    localparam int RST_IDX = 4;
    localparam int TST_IDX = 5;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SEC_W   = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLDING = 2'd1,
        FIRED   = 2'd2
    } hold_state_t;

    logic [NBTN-1:0] raw_vec;
    logic [NBTN-1:0] pin_lvl;
    logic [NBTN-1:0] sync_1;
    logic [NBTN-1:0] sync_2;
    logic [NBTN-1:0] stable;
    logic [DB_W-1:0] db_cnt [NBTN];

    logic [3:0] stable_d;
    logic [3:0] stable_dd;
    logic [3:0] care_pulse;
    logic [3:0] rep_fire;

    logic [1:0] fill;
    logic [1:0] armed;
    logic [1:0] active;

    hold_state_t      state_q [2];
    hold_state_t      state_d [2];
    logic [SEC_W-1:0] sec_q [2];
    logic [SEC_W-1:0] sec_d [2];
    logic [2:0]       cnt_q [2];
    logic [2:0]       cnt_d [2];
    logic [1:0]       fire_q;
    logic [1:0]       fire_d;

    // Polarity is normalised ahead of the synchronizer so cleared flops read as released.
    assign raw_vec = {raw_test, raw_reset, raw_diversion, raw_hambre, raw_energia, raw_salud};
    assign pin_lvl = (BTN_ACTIVE_LOW != 0) ? ~raw_vec : raw_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
            stable <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_1 <= pin_lvl;
            sync_2 <= sync_1;
            for (int i = 0; i < NBTN; i++) begin
                if (sync_2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync_2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d   <= '0;
            stable_dd  <= '0;
            care_pulse <= '0;
        end else begin
            stable_d   <= stable[3:0];
            stable_dd  <= stable_d;
            care_pulse <= (stable_d & ~stable_dd) | rep_fire;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int HOLD_SPAN = HOLD_SECS * SEC_CYCLES;
    localparam int RPT_MAX   = (HOLD_SPAN > REPEAT_CYCLES) ? HOLD_SPAN : REPEAT_CYCLES;
    localparam int RPT_W     = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt [4];
    logic [3:0]       rpt_phase;

    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < 4; i++) begin
            rep_fire[i] = rpt_phase[i] && stable[i] && stable_dd[i] &&
                          (rpt_cnt[i] == RPT_W'(REPEAT_CYCLES - 1));
        end
    end

    // First phase waits out the hold span after the press pulse, second phase emits repeats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_phase <= '0;
            for (int i = 0; i < 4; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!(stable[i] && stable_dd[i])) begin
                    rpt_cnt[i]   <= '0;
                    rpt_phase[i] <= 1'b0;
                end else if (!rpt_phase[i]) begin
                    if (rpt_cnt[i] == RPT_W'(HOLD_SPAN - 1)) begin
                        rpt_cnt[i]   <= '0;
                        rpt_phase[i] <= 1'b1;
                    end else begin
                        rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                    end
                end else if (rpt_cnt[i] == RPT_W'(REPEAT_CYCLES - 1)) begin
                    rpt_cnt[i] <= '0;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
    assign rep_fire      = '0;
`endif

    // A long-press button held through rst stays locked out until it has been seen released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill  <= '0;
            armed <= '0;
        end else begin
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end
            for (int i = 0; i < 2; i++) begin
                if (fill == 2'd2 && !stable[RST_IDX+i] && !sync_2[RST_IDX+i]) begin
                    armed[i] <= 1'b1;
                end
            end
        end
    end

    assign active[0] = stable[RST_IDX] & armed[0];
    assign active[1] = stable[TST_IDX] & armed[1] & ~stable[RST_IDX];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_q <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                sec_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            fire_q <= fire_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                sec_q[i]   <= sec_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        fire_d = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            sec_d[i]   = sec_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    sec_d[i] = '0;
                    cnt_d[i] = '0;
                    if (active[i]) begin
                        state_d[i] = HOLDING;
                    end
                end
                HOLDING, FIRED: begin
                    if (!active[i]) begin
                        state_d[i] = IDLE;
                        sec_d[i]   = '0;
                        cnt_d[i]   = '0;
                    end else if (sec_q[i] == SEC_W'(SEC_CYCLES - 1)) begin
                        sec_d[i] = '0;
                        if (cnt_q[i] != 3'd7) begin
                            cnt_d[i] = cnt_q[i] + 3'd1;
                        end
                        if (state_q[i] == HOLDING && (cnt_q[i] + 3'd1) == 3'(HOLD_SECS)) begin
                            fire_d[i]  = 1'b1;
                            state_d[i] = FIRED;
                        end
                    end else begin
                        sec_d[i] = sec_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    assign btn_salud     = care_pulse[0];
    assign btn_energia   = care_pulse[1];
    assign btn_hambre    = care_pulse[2];
    assign btn_diversion = care_pulse[3];
    assign btn_reset     = fire_q[0];
    assign btn_test      = fire_q[1];
    assign count_reset   = cnt_q[0];
    assign count_test    = cnt_q[1];

endmodule

// File: tb/tb_tamagotchi_btn_cond.sv
// Directed bench for tamagotchi_btn_cond with short debounce/second periods.
// Builds with or without BTN_AUTOREPEAT_EN; the long salud hold expectation follows the macro.
`timescale 1ns/1ps
module tb_tamagotchi_btn_cond;

    localparam int DEB  = 4;
    localparam int SEC  = 10;
    localparam int HOLD = 5;
    localparam int RPT  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       raw_salud = 1'b1;
    logic       raw_energia = 1'b1;
    logic       raw_hambre = 1'b1;
    logic       raw_diversion = 1'b1;
    logic       raw_reset = 1'b1;
    logic       raw_test = 1'b1;
    logic       btn_salud;
    logic       btn_energia;
    logic       btn_hambre;
    logic       btn_diversion;
    logic       btn_reset;
    logic       btn_test;
    logic [2:0] count_reset;
    logic [2:0] count_test;

    int total = 0;
    int bad   = 0;

    tamagotchi_btn_cond #(
        .BTN_ACTIVE_LOW (1),
        .DEBOUNCE_CYCLES(DEB),
        .SEC_CYCLES     (SEC),
        .HOLD_SECS      (HOLD),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_salud    (raw_salud),
        .raw_energia  (raw_energia),
        .raw_hambre   (raw_hambre),
        .raw_diversion(raw_diversion),
        .raw_reset    (raw_reset),
        .raw_test     (raw_test),
        .btn_salud    (btn_salud),
        .btn_energia  (btn_energia),
        .btn_hambre   (btn_hambre),
        .btn_diversion(btn_diversion),
        .btn_reset    (btn_reset),
        .btn_test     (btn_test),
        .count_reset  (count_reset),
        .count_test   (count_test)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pin levels: 0 = pressed (active-low board).
    task automatic applyStimulus(input logic s, input logic e, input logic h,
                                 input logic d, input logic r, input logic t);
        raw_salud     = s;
        raw_energia   = e;
        raw_hambre    = h;
        raw_diversion = d;
        raw_reset     = r;
        raw_test      = t;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Hold counter of a press whose first sampling edge is e=0, released at sampling edge rel.
    // Stable rises at e=5, FSM enters HOLDING at e=6, seconds tick at e=16,26,...
    // Stable falls at rel+5 and the count clears one clock later.
    function automatic int hold_count(input int e, input int rel);
        int n;
        if (e >= rel + 6) return 0;
        if (e < 16) return 0;
        n = (e - 6) / 10;
        return (n > 7) ? 7 : n;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e;
        bit exp_rep;

        applyStimulus(1, 1, 1, 1, 1, 1);
        rst = 1'b1;
        tick(3);
        checkOutput("reset btn_salud", btn_salud, 0);
        checkOutput("reset btn_energia", btn_energia, 0);
        checkOutput("reset btn_hambre", btn_hambre, 0);
        checkOutput("reset btn_diversion", btn_diversion, 0);
        checkOutput("reset btn_reset", btn_reset, 0);
        checkOutput("reset btn_test", btn_test, 0);
        checkOutput("reset count_reset", count_reset, 0);
        checkOutput("reset count_test", count_test, 0);
        rst = 1'b0;
        tick(10);

        $display("[TB] step 1: salud press, pulse 7 clocks after first sampling edge");
        applyStimulus(0, 1, 1, 1, 1, 1);
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            e = c - 1;
            checkOutput($sformatf("t1 btn_salud e=%0d", e), btn_salud, (e == 7));
        end
        applyStimulus(1, 1, 1, 1, 1, 1);
        for (int c = 1; c <= 15; c++) begin
            tick(1);
            checkOutput($sformatf("t1 release btn_salud c=%0d", c), btn_salud, 0);
        end

        $display("[TB] step 2: 3-cycle hambre glitch is filtered");
        applyStimulus(1, 1, 0, 1, 1, 1);
        tick(3);
        applyStimulus(1, 1, 1, 1, 1, 1);
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            checkOutput($sformatf("t2 btn_hambre c=%0d", c), btn_hambre, 0);
        end

        $display("[TB] step 3: reset held 80 cycles");
        applyStimulus(1, 1, 1, 1, 0, 1);
        for (int c = 1; c <= 100; c++) begin
            tick(1);
            e = c - 1;
            checkOutput($sformatf("t3 count_reset e=%0d", e), count_reset, 4'(hold_count(e, 80)));
            checkOutput($sformatf("t3 btn_reset e=%0d", e), btn_reset, (e == 56));
            checkOutput($sformatf("t3 btn_test e=%0d", e), btn_test, 0);
            if (c == 80) applyStimulus(1, 1, 1, 1, 1, 1);
        end
        tick(10);

        $display("[TB] step 4: test held 30 cycles, then a fresh hold");
        applyStimulus(1, 1, 1, 1, 1, 0);
        for (int c = 1; c <= 45; c++) begin
            tick(1);
            e = c - 1;
            checkOutput($sformatf("t4a count_test e=%0d", e), count_test, 4'(hold_count(e, 30)));
            checkOutput($sformatf("t4a btn_test e=%0d", e), btn_test, 0);
            if (c == 30) applyStimulus(1, 1, 1, 1, 1, 1);
        end
        tick(5);
        applyStimulus(1, 1, 1, 1, 1, 0);
        for (int c = 1; c <= 25; c++) begin
            tick(1);
            e = c - 1;
            checkOutput($sformatf("t4b count_test e=%0d", e), count_test, (e >= 16));
        end
        applyStimulus(1, 1, 1, 1, 1, 1);
        tick(15);
        checkOutput("t4b count_test released", count_test, 0);

        $display("[TB] step 5: reset and test together, reset wins");
        applyStimulus(1, 1, 1, 1, 0, 0);
        for (int c = 1; c <= 100; c++) begin
            tick(1);
            e = c - 1;
            checkOutput($sformatf("t5 count_reset e=%0d", e), count_reset, 4'(hold_count(e, 80)));
            checkOutput($sformatf("t5 btn_reset e=%0d", e), btn_reset, (e == 56));
            checkOutput($sformatf("t5 count_test e=%0d", e), count_test, 0);
            checkOutput($sformatf("t5 btn_test e=%0d", e), btn_test, 0);
            if (c == 80) applyStimulus(1, 1, 1, 1, 1, 1);
        end
        tick(10);

        $display("[TB] step 6: rst mid-hold aborts until release and re-press");
        applyStimulus(1, 1, 1, 1, 0, 1);
        tick(41);
        checkOutput("t6 count_reset before rst", count_reset, 3);
        rst = 1'b1;
        #1;
        checkOutput("t6 rst count_reset", count_reset, 0);
        checkOutput("t6 rst btn_reset", btn_reset, 0);
        checkOutput("t6 rst count_test", count_test, 0);
        checkOutput("t6 rst btn_test", btn_test, 0);
        checkOutput("t6 rst btn_salud", btn_salud, 0);
        tick(2);
        rst = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            tick(1);
            checkOutput($sformatf("t6 locked count_reset c=%0d", c), count_reset, 0);
            checkOutput($sformatf("t6 locked btn_reset c=%0d", c), btn_reset, 0);
        end
        applyStimulus(1, 1, 1, 1, 1, 1);
        for (int c = 1; c <= 15; c++) begin
            tick(1);
            checkOutput($sformatf("t6 release btn_reset c=%0d", c), btn_reset, 0);
        end
        applyStimulus(1, 1, 1, 1, 0, 1);
        for (int c = 1; c <= 60; c++) begin
            tick(1);
            e = c - 1;
            checkOutput($sformatf("t6 repress count_reset e=%0d", e), count_reset, 4'(hold_count(e, 1000)));
            checkOutput($sformatf("t6 repress btn_reset e=%0d", e), btn_reset, (e == 56));
        end
        applyStimulus(1, 1, 1, 1, 1, 1);
        tick(15);

        $display("[TB] step 7: energia and diversion pressed together");
        applyStimulus(1, 0, 1, 0, 1, 1);
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            e = c - 1;
            checkOutput($sformatf("t7 btn_energia e=%0d", e), btn_energia, (e == 7));
            checkOutput($sformatf("t7 btn_diversion e=%0d", e), btn_diversion, (e == 7));
            checkOutput($sformatf("t7 btn_salud e=%0d", e), btn_salud, 0);
        end
        applyStimulus(1, 1, 1, 1, 1, 1);
        tick(15);

        $display("[TB] step 8: salud held 120 cycles");
        applyStimulus(0, 1, 1, 1, 1, 1);
        for (int c = 1; c <= 140; c++) begin
            tick(1);
            e = c - 1;
`ifdef BTN_AUTOREPEAT_EN
            exp_rep = (e >= 67) && (e <= 117) && (((e - 67) % 10) == 0);
`else
            exp_rep = 1'b0;
`endif
            checkOutput($sformatf("t8 btn_salud e=%0d", e), btn_salud, ((e == 7) || exp_rep));
            if (c == 120) applyStimulus(1, 1, 1, 1, 1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
